// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   uart_state_t : serializer FSM states
//   ST_*         : bit positions inside the STATUS word
//   *_OFS        : register byte offsets from the block base address
//   status_word(): packs the STATUS fields into a 32-bit read value
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  localparam logic [31:0] DATA_OFS   = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  // Count is passed zero-extended to 16 bits; every bit not driven here reads 0.
  function automatic logic [31:0] status_word(input logic        full,
                                              input logic        empty,
                                              input logic        busy,
                                              input logic        ovf,
                                              input logic [15:0] cnt);
    logic [31:0] w;
    w                     = '0;
    w[ST_FULL]            = full;
    w[ST_EMPTY]           = empty;
    w[ST_BUSY]            = busy;
    w[ST_OVF]             = ovf;
    w[ST_CNT_LSB +: 16]   = cnt;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read.
//   clk   : clock
//   reset : asynchronous active-low reset (pointers and count cleared)
//   push  : enqueue din; accepted when not full, or when full with a pop
//   pop   : dequeue the head; ignored when empty
//   din   : write data
//   dout  : current head entry (valid while !empty)
//   full  : count == DEPTH
//   empty : count == 0
//   count : number of stored entries, $clog2(DEPTH)+1 bits
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted; the write lands in the slot the head is leaving.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Head is read combinationally so the consumer can capture it on the pop edge.
  assign dout = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the data-memory bus.
//   clk       : clock
//   reset     : asynchronous active-low reset
//   memWrite  : store strobe
//   dataAddr  : bus byte address
//   writeData : store data (DATA uses [7:0], STATUS uses [3] as overflow clear)
//   hit       : dataAddr selects DATA or STATUS (combinational)
//   readData  : STATUS word when STATUS is addressed, else 0 (combinational)
//   tx        : registered serial line, idles high
//   busy      : serializer is sending a frame
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memWrite,
  input  logic [31:0] dataAddr,
  input  logic [31:0] writeData,
  output logic        hit,
  output logic [31:0] readData,
  output logic        tx,
  output logic        busy
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // ---------------- address decode ----------------
  logic sel_data;
  logic sel_stat;

  assign sel_data = (dataAddr == BASE_ADDR + DATA_OFS);
  assign sel_stat = (dataAddr == BASE_ADDR + STATUS_OFS);
  assign hit      = sel_data || sel_stat;

  // ---------------- FIFO ----------------
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  uart_state_t   state_q;

  assign fifo_push = memWrite && sel_data;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (writeData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------- overflow flag ----------------
  logic ovf_q, ovf_d;
  logic drop;
  logic ovf_clr;

  assign drop    = fifo_push && fifo_full && !fifo_pop;
  assign ovf_clr = memWrite && sel_stat && writeData[ST_OVF];

  // A dropped byte in the same cycle as a clear leaves the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  // ---------------- serializer ----------------
  logic [CNT_W-1:0] clk_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;
  logic             tx_q;
  logic             busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            // The pop happens on this edge; the start bit appears right after it.
            shreg_q   <= fifo_dout;
            clk_cnt_q <= '0;
            state_q   <= START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
            tx_q      <= shreg_q[0];
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shreg_q[bit_idx_q + 3'd1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

  // ---------------- STATUS read ----------------
  assign readData = sel_stat ? status_word(fifo_full, fifo_empty, busy_q, ovf_q, 16'(fifo_count))
                             : 32'h0;

  // Only the data byte and the overflow-clear bit of a store carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^{writeData[31:8]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memWrite = 1'b0;
  logic [31:0] dataAddr = 32'h0;
  logic [31:0] writeData = 32'h0;
  logic        hit;
  logic [31:0] readData;
  logic        tx;
  logic        busy;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memWrite  (memWrite),
    .dataAddr  (dataAddr),
    .writeData (writeData),
    .hit       (hit),
    .readData  (readData),
    .tx        (tx),
    .busy      (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // FIFO as a queue; a frame is a byte plus the number of cycles since its
  // start bit, from which the line level follows by division.
  byte unsigned mq[$];
  bit           m_active = 0;
  bit [7:0]     m_byte   = 0;
  int           m_pos    = 0;
  bit           m_ovf    = 0;
  bit           chk_en   = 0;

  function automatic logic m_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / CPB;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s       = 32'h0;
    s[0]    = (mq.size() == DEPTH);
    s[1]    = (mq.size() == 0);
    s[2]    = m_active;
    s[3]    = m_ovf;
    s[11:8] = 4'(mq.size());
    return s;
  endfunction

  // serial-line decoder
  bit           rx_on   = 0;
  int           rx_cnt  = 0;
  bit [7:0]     rx_sh   = 0;
  byte unsigned rxq[$];
  logic         tx_prev = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        mq.delete();
        m_active = 0;
        m_pos    = 0;
        m_ovf    = 0;
        rx_on    = 0;
        tx_prev  = 1'b1;
        if (chk_en) begin
          chk("reset_tx", tx, 1'b1);
          chk("reset_busy", busy, 1'b0);
        end
      end else begin
        bit pop_now, push_req, drop, clr;
        if (chk_en) begin
          chk("tx", tx, m_tx());
          chk("busy", busy, m_active);
          chk("hit", hit, (dataAddr == BASE) || (dataAddr == BASE + 32'd4));
          chk("readData", readData, (dataAddr == BASE + 32'd4) ? m_status() : 32'h0);
        end
        // decode the line
        if (!rx_on) begin
          if (tx_prev && !tx) begin
            rx_on  = 1;
            rx_cnt = 0;
          end
        end else begin
          rx_cnt++;
          if ((rx_cnt % CPB) == CPB/2 && rx_cnt/CPB >= 1 && rx_cnt/CPB <= 8)
            rx_sh[rx_cnt/CPB - 1] = tx;
          if (rx_cnt == 9*CPB + CPB/2) begin
            rxq.push_back(rx_sh);
            rx_on = 0;
          end
        end
        tx_prev = tx;
        // advance the model with the inputs the next rising edge will sample
        pop_now  = !m_active && (mq.size() != 0);
        push_req = memWrite && (dataAddr == BASE);
        drop     = push_req && (mq.size() == DEPTH) && !pop_now;
        clr      = memWrite && (dataAddr == BASE + 32'd4) && writeData[3];
        if (pop_now) begin
          m_byte   = mq.pop_front();
          m_active = 1;
          m_pos    = 0;
        end else if (m_active) begin
          m_pos++;
          if (m_pos == 10*CPB) m_active = 0;
        end
        if (push_req && !drop) mq.push_back(writeData[7:0]);
        if (drop)     m_ovf = 1;
        else if (clr) m_ovf = 0;
      end
    end
  end

  // ---------------- stimulus (every task ends 1 time unit after a rising edge) ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memWrite  = 1'b1;
    dataAddr  = a;
    writeData = d;
    $display("WR addr=%h data=%h", a, d);
    @(posedge clk); #1;
    memWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    dataAddr = BASE + 32'd4;
    #0;
    while (!(readData[1] && !busy) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, (n < 1000), 1'b1);
  endtask

  initial begin
    logic       txh [0:50];
    logic       bh  [0:50];
    logic [7:0] b55;
    int         bcnt;

    #2 reset = 1'b0;
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    dataAddr = BASE + 32'd4;
    idle(1);
    chk("reset_status", readData, 32'h0000_0002);
    chk("reset_hit", hit, 1'b1);
    chk("idle_tx", tx, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // single byte 0x55: literal waveform
    b55 = 8'h55;
    wr(BASE, 32'hABCD_1255);
    txh[1] = tx;
    bh[1]  = busy;
    for (int c = 2; c <= 50; c++) begin
      @(posedge clk); #1;
      txh[c] = tx;
      bh[c]  = busy;
    end
    chk("pre_start_high", txh[1], 1'b1);
    chk("start_bit_lat2", txh[2], 1'b0);
    chk("start_bit_end", txh[5], 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("data_bit_first", txh[6 + 4*i], b55[i]);
      chk("data_bit_last", txh[9 + 4*i], b55[i]);
    end
    chk("stop_bit", txh[38], 1'b1);
    bcnt = 0;
    for (int c = 1; c <= 50; c++) if (bh[c]) bcnt++;
    chk("busy_cycles_40", bcnt, 40);
    chk("busy_last", bh[41], 1'b1);
    chk("busy_off", bh[42], 1'b0);

    // burst of 10 stores: 9 accepted, 10th dropped
    rxq.delete();
    for (int i = 1; i <= 10; i++) begin
      memWrite  = 1'b1;
      dataAddr  = BASE;
      writeData = 32'(i);
      $display("WR addr=%h data=%h", BASE, 32'(i));
      @(posedge clk); #1;
    end
    memWrite = 1'b0;
    dataAddr = BASE + 32'd4;
    #1;
    chk("burst_status", readData, 32'h0000_080D);
    wait_drain("burst_drain_timeout");
    chk("burst_rx_count", rxq.size(), 9);
    for (int i = 0; i < 9 && i < rxq.size(); i++)
      chk("burst_rx_byte", rxq[i], 32'(i + 1));
    chk("after_burst_status", readData, 32'h0000_000A);

    // overflow clear behaviour
    wr(BASE + 32'd4, 32'hFFFF_FFF7);
    chk("ovf_kept", readData, 32'h0000_000A);
    wr(BASE + 32'd4, 32'h0000_0008);
    chk("ovf_cleared", readData, 32'h0000_0002);

    // non-hit addresses
    wr(BASE + 32'd8, 32'h0000_00AA);
    chk("nohit_hit", hit, 1'b0);
    chk("nohit_rdata", readData, 32'h0);
    wr(32'h0000_0040, 32'h0000_00BB);
    chk("nohit2_hit", hit, 1'b0);
    chk("nohit2_rdata", readData, 32'h0);
    dataAddr = BASE + 32'd4;
    idle(3);
    chk("nohit_status", readData, 32'h0000_0002);

    // randomized traffic against the model
    for (int c = 0; c < 700; c++) begin
      int sel;
      memWrite = ($urandom_range(0, 2) == 0);
      sel      = $urandom_range(0, 5);
      case (sel)
        0, 1, 2: dataAddr = BASE;
        3:       dataAddr = BASE + 32'd4;
        4:       dataAddr = BASE + 32'd8;
        default: dataAddr = $urandom;
      endcase
      writeData = $urandom;
      if (memWrite) $display("WR addr=%h data=%h", dataAddr, writeData);
      @(posedge clk); #1;
    end
    memWrite = 1'b0;
    wait_drain("random_drain_timeout");
    wr(BASE + 32'd4, 32'h0000_0008);

    // reset in the middle of a frame
    wr(BASE, 32'h0000_00C3);
    wr(BASE, 32'h0000_0011);
    idle(12);
    chk("pre_reset_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("async_reset_tx", tx, 1'b1);
    chk("async_reset_busy", busy, 1'b0);
    idle(2);
    reset = 1'b1;
    dataAddr = BASE + 32'd4;
    #1;
    chk("post_reset_status", readData, 32'h0000_0002);
    idle(60);
    chk("flushed_busy", busy, 1'b0);
    chk("flushed_status", readData, 32'h0000_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
